// File: rtl/uart_transmit_fifo.sv
// UART transmitter with a small transmit FIFO. Frame format (data width,
// parity, stop bits) and bit timing are fixed by parameters. Words queued on
// the write side are sent back to back, LSB first, with no idle gap between
// frames while the FIFO holds data.
module uart_transmit_fifo #(
    parameter int ClockFreq  = 100_000_000,
    parameter int BaudRate   = 115_200,
    parameter int DataBits   = 8,
    parameter int ParityMode = 0,
    parameter int StopBits   = 1,
    parameter int FifoDepth  = 8
) (
    input  logic                       Clock,
    input  logic                       ResetN,
    input  logic [DataBits-1:0]        DataIn,
    input  logic                       DataInValid,
    output logic                       DataInReady,
    output logic                       SOut,
    output logic                       Busy,
    output logic [$clog2(FifoDepth):0] FifoCount
);

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int CntW           = $clog2(SymbolEdgeTime);
    localparam int PtrW           = $clog2(FifoDepth);
    localparam int CountW         = PtrW + 1;
    localparam int BitW           = $clog2(DataBits);

    localparam logic [CntW-1:0]   LastTick  = CntW'(SymbolEdgeTime - 1);
    localparam logic [BitW-1:0]   LastData  = BitW'(DataBits - 1);
    localparam logic [BitW-1:0]   LastStop  = BitW'(StopBits - 1);
    localparam logic [CountW-1:0] FullCount = CountW'(FifoDepth);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DataBits-1:0] r_mem [FifoDepth];
    logic [PtrW-1:0]     r_wr_ptr;
    logic [PtrW-1:0]     r_rd_ptr;
    logic [CountW-1:0]   r_count;

    // Transmit datapath
    state_t              r_state;
    logic [CntW-1:0]     r_baud_cnt;
    logic [BitW-1:0]     r_bit_cnt;
    logic [DataBits-1:0] r_shift;
    logic                r_parity;
    logic                r_sout;

    state_t              w_next_state;
    logic [DataBits-1:0] w_next_shift;
    logic                w_next_sout;
    logic                w_push;
    logic                w_pop;
    logic                w_tick;
    logic                w_not_empty;
    logic [DataBits-1:0] w_head;

    assign DataInReady = (r_count != FullCount);
    assign w_push      = DataInValid && DataInReady;
    assign w_not_empty = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_tick      = (r_baud_cnt == LastTick);

    assign SOut      = r_sout;
    assign Busy      = (r_state != IDLE);
    assign FifoCount = r_count;

    // FIFO word storage, written on an accepted push
    // NOTE: storage is deliberately left out of reset; the pointers and count
    // define what is valid, so stale contents are never observed.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DataIn;
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave the count alone
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state logic; pops happen from IDLE or on the last stop-bit edge
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_shift = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_next_shift = w_head;
                    w_next_state = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_next_shift = r_shift >> 1;
                    if (r_bit_cnt == LastData) begin
                        w_next_state = (ParityMode != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_tick && (r_bit_cnt == LastStop)) begin
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_next_shift = w_head;
                        w_next_state = START;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Line level for the state being entered, so SOut can be a plain flop
    always_comb begin
        case (w_next_state)
            START:   w_next_sout = 1'b0;
            DATA:    w_next_sout = w_next_shift[0];
            PARITY:  w_next_sout = r_parity;
            default: w_next_sout = 1'b1;
        endcase
    end

    // State, bit timing, shift register and registered serial output
    // NOTE: non-blocking assignments throughout, so every flop samples the
    // values from before the edge regardless of statement order.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_sout     <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_shift <= w_next_shift;
            r_sout  <= w_next_sout;
            if (w_pop) begin
                r_parity <= (ParityMode == 2) ? ~(^w_head) : ^w_head;
            end
            if (w_pop || w_tick || (r_state == IDLE)) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (w_pop || (w_next_state != r_state)) begin
                r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_transmit_fifo.sv
// Bench for uart_transmit_fifo: four instances (8E1, 8O2, 5N1, 8N1) at 16
// clocks per bit. Single frames come from a vector table; FIFO fill,
// push/pop on the final stop edge and mid-frame reset are hand sequences.
module tb_uart_transmit_fifo;

    localparam int Sym    = 16;
    localparam int NTrace = 1445;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      din = '0;
    logic [3:0]      valid = '0;
    logic [3:0]      ready;
    logic [3:0]      sout;
    logic [3:0]      busy;
    logic [3:0][3:0] cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] sb[$];
    logic        tr_s [NTrace];
    logic        tr_b [NTrace];

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] expv;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    uart_transmit_fifo #(.ClockFreq(16), .BaudRate(1), .DataBits(8), .ParityMode(1),
                         .StopBits(1), .FifoDepth(8)) u_e1 (
        .Clock(clk), .ResetN(rst_n), .DataIn(din), .DataInValid(valid[0]),
        .DataInReady(ready[0]), .SOut(sout[0]), .Busy(busy[0]), .FifoCount(cnt[0]));

    uart_transmit_fifo #(.ClockFreq(16), .BaudRate(1), .DataBits(8), .ParityMode(2),
                         .StopBits(2), .FifoDepth(8)) u_o2 (
        .Clock(clk), .ResetN(rst_n), .DataIn(din), .DataInValid(valid[1]),
        .DataInReady(ready[1]), .SOut(sout[1]), .Busy(busy[1]), .FifoCount(cnt[1]));

    uart_transmit_fifo #(.ClockFreq(16), .BaudRate(1), .DataBits(5), .ParityMode(0),
                         .StopBits(1), .FifoDepth(8)) u_n5 (
        .Clock(clk), .ResetN(rst_n), .DataIn(din[4:0]), .DataInValid(valid[2]),
        .DataInReady(ready[2]), .SOut(sout[2]), .Busy(busy[2]), .FifoCount(cnt[2]));

    uart_transmit_fifo #(.ClockFreq(16), .BaudRate(1), .DataBits(8), .ParityMode(0),
                         .StopBits(1), .FifoDepth(8)) u_n1 (
        .Clock(clk), .ResetN(rst_n), .DataIn(din), .DataInValid(valid[3]),
        .DataInReady(ready[3]), .SOut(sout[3]), .Busy(busy[3]), .FifoCount(cnt[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid = '0;
        din   = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Push one word into an idle instance and capture its whole frame.
    task automatic run_frame(input int sel, input logic [7:0] data, input int nbits,
                             input logic [11:0] expv, input string name);
        logic [11:0] got;
        int          unstable;
        int          busy_n;
        din        = data;
        valid[sel] = 1'b1;
        sb.push_back(expv);
        @(posedge clk);
        #1 valid[sel] = 1'b0;
        @(negedge clk);
        check({name, " line_before_start"}, {30'd0, busy[sel], sout[sel]}, 32'd1);
        check({name, " count_after_push"}, cnt[sel], 32'd1);
        got      = '0;
        unstable = 0;
        busy_n   = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < Sym; c++) begin
                @(negedge clk);
                if (c == 0) got[b] = sout[sel];
                else if (sout[sel] !== got[b]) unstable++;
                if (busy[sel] === 1'b1) busy_n++;
            end
        end
        @(negedge clk);
        check({name, " bits"}, got, sb.pop_front());
        check({name, " bit_width"}, unstable, 32'd0);
        check({name, " busy_cycles"}, busy_n, nbits * Sym);
        check({name, " idle_after"}, {30'd0, busy[sel], sout[sel]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int          m_count;
        bit          m_busy;
        bit          acc;
        bit          pop;
        int          n_tr;
        int          unstable;
        int          gaps;
        int          bad;
        logic [11:0] f;

        vecs[0] = '{0, 8'hA5, 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}};
        vecs[1] = '{1, 8'h00, 12, {1'b1, 1'b1, 1'b1, 8'h00, 1'b0}};
        vecs[2] = '{2, 8'h1F, 7,  {5'b0, 1'b1, 5'h1F, 1'b0}};
        vecs[3] = '{0, 8'h01, 11, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}};
        vecs[4] = '{1, 8'h80, 12, {1'b1, 1'b1, 1'b0, 8'h80, 1'b0}};
        vecs[5] = '{2, 8'h0A, 7,  {5'b0, 1'b1, 5'h0A, 1'b0}};
        vecs[6] = '{3, 8'h3C, 10, {2'b0, 1'b1, 8'h3C, 1'b0}};

        // Reset state of every instance
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_sout%0d", i), sout[i], 32'd1);
            check($sformatf("reset_busy%0d", i), busy[i], 32'd0);
            check($sformatf("reset_ready%0d", i), ready[i], 32'd1);
            check($sformatf("reset_count%0d", i), cnt[i], 32'd0);
        end

        // Single frames from the vector table
        for (int k = 0; k < 7; k++) begin
            run_frame(vecs[k].sel, vecs[k].data, vecs[k].nbits, vecs[k].expv,
                      $sformatf("vec%0d", k));
        end

        // FIFO fill: ten back-to-back pushes into 8N1, depth 8
        do_reset();
        m_count = 0;
        m_busy  = 1'b0;
        n_tr    = 0;
        for (int t = 0; t < 10; t++) begin
            din      = 8'h30 + 8'(t);
            valid[3] = 1'b1;
            check($sformatf("fill_ready%0d", t), ready[3], {31'd0, m_count != 8});
            acc = (m_count != 8);
            if (acc) sb.push_back({2'b0, 1'b1, din, 1'b0});
            @(posedge clk);
            pop     = !m_busy && (m_count > 0);
            m_count = m_count + int'(acc) - int'(pop);
            if (pop) m_busy = 1'b1;
            @(negedge clk);
            tr_s[n_tr] = sout[3];
            tr_b[n_tr] = busy[3];
            n_tr++;
            check($sformatf("fill_count%0d", t), cnt[3], m_count);
        end
        valid[3] = 1'b0;
        while (n_tr < NTrace) begin
            @(negedge clk);
            tr_s[n_tr] = sout[3];
            tr_b[n_tr] = busy[3];
            n_tr++;
        end
        check("fill_first_start", {30'd0, tr_s[0], tr_s[1]}, 32'd2);
        unstable = 0;
        for (int j = 0; j < 9; j++) begin
            f = '0;
            for (int b = 0; b < 10; b++) begin
                f[b] = tr_s[1 + 160 * j + Sym * b];
                for (int c = 1; c < Sym; c++) begin
                    if (tr_s[1 + 160 * j + Sym * b + c] !== f[b]) unstable++;
                end
            end
            check($sformatf("fill_frame%0d", j), f, sb.pop_front());
        end
        check("fill_bit_width", unstable, 32'd0);
        gaps = 0;
        for (int i = 1; i <= 1440; i++) begin
            if (tr_b[i] !== 1'b1) gaps++;
        end
        check("fill_no_gap", gaps, 32'd0);
        check("fill_idle_after", {30'd0, tr_b[1441], tr_s[1441]}, 32'd1);
        check("fill_empty_after", cnt[3], 32'd0);

        // Push exactly on the final stop-bit edge with three words queued
        do_reset();
        valid[3] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            din = 8'h40 + 8'(t);
            tick();
        end
        valid[3] = 1'b0;
        check("simul_count_queued", cnt[3], 32'd3);
        repeat (157) tick();
        check("simul_stop_level", sout[3], 32'd1);
        check("simul_count_before", cnt[3], 32'd3);
        din      = 8'h44;
        valid[3] = 1'b1;
        tick();
        valid[3] = 1'b0;
        check("simul_count_after", cnt[3], 32'd3);
        check("simul_next_start", {30'd0, busy[3], sout[3]}, 32'd2);

        // Asynchronous reset during data bit 4 with two words queued
        do_reset();
        valid[3] = 1'b1;
        din      = 8'h0F;
        tick();
        din      = 8'h11;
        tick();
        din      = 8'h22;
        tick();
        valid[3] = 1'b0;
        check("rst_count_queued", cnt[3], 32'd2);
        repeat (87) tick();
        check("rst_data_bit4", sout[3], 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_sout", sout[3], 32'd1);
        check("rst_async_count", cnt[3], 32'd0);
        check("rst_async_busy", busy[3], 32'd0);
        check("rst_async_ready", ready[3], 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (sout[3] !== 1'b1 || busy[3] !== 1'b0) bad++;
        end
        check("rst_stays_idle", bad, 32'd0);
        run_frame(3, 8'h5A, 10, {2'b0, 1'b1, 8'h5A, 1'b0}, "rst_new_frame");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
